// File: rtl/armsim_pkg.sv
// Shared definitions for the load path.
//   size_e      : load size codes, shared with the sign-extension stage
//   la_state_e  : load_aligner FSM states
//   FC_*        : fault codes reported on FCODE
//   is_aligned  : natural-alignment test for a byte address and size
package armsim_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        LA_IDLE,
        LA_ACC1,
        LA_ACC2,
        LA_DONE,
        LA_ERR
    } la_state_e;

    localparam logic FC_MISALIGN = 1'b0;
    localparam logic FC_TIMEOUT  = 1'b1;

    // An access is aligned when the address is a multiple of its size in bytes.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input size_e size);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (addr_lo[0] == 1'b0);
            SZ_WORD: ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_aligner_lane_select.sv
// lane_select: picks the addressed lane out of a little-endian memory word.
//   mrd     in  32  memory read word
//   addr_lo in  2   byte offset within the word
//   size    in  2   load size code
//   lane    out 32  selected lane, right-justified, zero-filled
//                   (word and doubleword pass the whole word through)
module lane_select
    import armsim_pkg::*;
(
    input  logic [31:0] mrd,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    output logic [31:0] lane
);

    always_comb begin
        // NOTE: give every combinational output a value before any branch so no path leaves it unassigned (which would infer a latch).
        lane = mrd;
        case (size)
            SZ_BYTE: lane = {24'h0, mrd[{addr_lo, 3'b000} +: 8]};
            SZ_HALF: lane = {16'h0, mrd[{addr_lo[1], 4'b0000} +: 16]};
            default: lane = mrd;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// load_aligner: load-path stage feeding the sign-extension stage.
// Runs the word-wide memory read handshake for a byte/half/word/doubleword
// load, aligns the addressed lane and hands it on with a one-cycle enable.
//   CLK, CLR       clock; synchronous active-high reset
//   START/ADDR/SIZE  load request, sampled only while idle
//   MOV/MA         memory read request and word address (MA[1:0] = 0)
//   MRD/MOC        memory read data and completion strobe
//   DQ/DQ_HI/DSIZE aligned result (DQ_HI only for doublewords) and size code
//   E              one-cycle pulse, result valid
//   BUSY           high whenever a request is in flight
//   FAULT/FCODE    one-cycle abort pulse; 0 misaligned, 1 timeout
module load_aligner
    import armsim_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic [31:0] ADDR,
    input  logic [1:0]  SIZE,
    output logic        MOV,
    output logic [31:0] MA,
    input  logic [31:0] MRD,
    input  logic        MOC,
    output logic [31:0] DQ,
    output logic [31:0] DQ_HI,
    output logic [1:0]  DSIZE,
    output logic        E,
    output logic        BUSY,
    output logic        FAULT,
    output logic        FCODE
);

    la_state_e        state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    size_e            size_q, size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gap_q, gap_d;     // first ACC2 cycle: mandatory MOV-low gap
    logic [31:0]      lo_q, lo_d;       // doubleword low word held until DONE
    logic             fcode_q, fcode_d;
    logic [31:0]      dq_q, dq_d;
    logic [31:0]      dq_hi_q, dq_hi_d;
    size_e            dsize_q, dsize_d;

    logic [31:0]      lane;
    logic [31:0]      word_addr;
    logic [CNT_W-1:0] cnt_inc;
    logic             mov;

    lane_select u_lane_select (
        .mrd     (MRD),
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .lane    (lane)
    );

    assign word_addr = {addr_q[31:2], 2'b00};
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign mov       = (state_q == LA_ACC1) || ((state_q == LA_ACC2) && !gap_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        lo_d    = lo_q;
        fcode_d = fcode_q;
        dq_d    = dq_q;
        dq_hi_d = dq_hi_q;
        dsize_d = dsize_q;

        case (state_q)
            LA_IDLE: begin
                if (START) begin
                    addr_d = ADDR;
                    size_d = size_e'(SIZE);
                    cnt_d  = '0;
                    if (is_aligned(ADDR[2:0], size_e'(SIZE))) begin
                        state_d = LA_ACC1;
                    end else begin
                        state_d = LA_ERR;
                        fcode_d = FC_MISALIGN;
                    end
                end
            end
            LA_ACC1, LA_ACC2: begin
                // MOC only counts while MOV is actually high; the ACC2 gap cycle ignores it.
                if (mov) begin
                    if (MOC) begin
                        if ((state_q == LA_ACC1) && (size_q == SZ_DWORD)) begin
                            lo_d    = lane;
                            cnt_d   = '0;
                            gap_d   = 1'b1;
                            state_d = LA_ACC2;
                        end else begin
                            // Result registers change only on the way into DONE,
                            // so they hold steady between E pulses and across faults.
                            dq_d    = (state_q == LA_ACC1) ? lane : lo_q;
                            dq_hi_d = (state_q == LA_ACC1) ? 32'h0 : MRD;
                            dsize_d = size_q;
                            state_d = LA_DONE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(TIMEOUT)) begin
                            state_d = LA_ERR;
                            fcode_d = FC_TIMEOUT;
                        end
                    end
                end
            end
            LA_DONE: state_d = LA_IDLE;
            LA_ERR:  state_d = LA_IDLE;
            default: state_d = LA_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (CLR) begin
            state_q <= LA_IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            lo_q    <= '0;
            fcode_q <= 1'b0;
            dq_q    <= '0;
            dq_hi_q <= '0;
            dsize_q <= SZ_BYTE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            lo_q    <= lo_d;
            fcode_q <= fcode_d;
            dq_q    <= dq_d;
            dq_hi_q <= dq_hi_d;
            dsize_q <= dsize_d;
        end
    end

    assign MOV   = mov;
    assign MA    = !mov ? 32'h0 : (state_q == LA_ACC1) ? word_addr : word_addr + 32'd4;
    assign DQ    = dq_q;
    assign DQ_HI = dq_hi_q;
    assign DSIZE = dsize_q;
    assign E     = (state_q == LA_DONE);
    assign BUSY  = (state_q != LA_IDLE);
    assign FAULT = (state_q == LA_ERR);
    assign FCODE = (state_q == LA_ERR) && fcode_q;

endmodule

// File: tb/tb_load_aligner.sv
// Self-checking bench for load_aligner. Inputs are driven and outputs sampled
// on the falling edge; cycle 0 is the cycle in which START is presented.
module tb_load_aligner;
    import armsim_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clr, start, moc;
    logic [31:0] addr, mrd;
    logic [1:0]  size;
    logic        mov, e, busy, fault, fcode;
    logic [31:0] ma, dq, dq_hi;
    logic [1:0]  dsize;

    int errors = 0;
    int checks = 0;

    // Result the DUT should currently be holding on DQ/DQ_HI/DSIZE.
    logic [31:0] exp_dq    = 32'h0;
    logic [31:0] exp_dq_hi = 32'h0;
    logic [1:0]  exp_dsize = 2'b00;

    always #5 clk = ~clk;

    load_aligner #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .CLK   (clk),
        .CLR   (clr),
        .START (start),
        .ADDR  (addr),
        .SIZE  (size),
        .MOV   (mov),
        .MA    (ma),
        .MRD   (mrd),
        .MOC   (moc),
        .DQ    (dq),
        .DQ_HI (dq_hi),
        .DSIZE (dsize),
        .E     (e),
        .BUSY  (busy),
        .FAULT (fault),
        .FCODE (fcode)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit model_aligned(input logic [31:0] a, input logic [1:0] sz);
        int unsigned nbytes;
        nbytes = 1 << sz;
        return (a % nbytes) == 0;
    endfunction

    function automatic logic [31:0] model_lane(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz);
        int unsigned nbytes;
        int unsigned off;
        nbytes = 1 << sz;
        off    = a % 4;
        if (nbytes >= 4) return w;
        return (w >> (8 * off)) & ((32'd1 << (8 * nbytes)) - 32'd1);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // One memory access: MOV/MA must hold for k waiting cycles, MOC on cycle k.
    task automatic access(input logic [31:0] exp_ma, input int k, input logic [31:0] w,
                          input string tag);
        for (int i = 0; i <= k; i++) begin
            checks++;
            if (mov !== 1'b1 || ma !== exp_ma || e !== 1'b0 || busy !== 1'b1 || dq !== exp_dq) begin
                errors++;
                $display("FAIL %s access cyc%0d: mov=%b ma=%h e=%b busy=%b dq=%h want mov=1 ma=%h e=0 busy=1 dq=%h",
                         tag, i, mov, ma, e, busy, dq, exp_ma, exp_dq);
            end
            moc = (i == k);
            mrd = (i == k) ? w : $urandom;
            step();
        end
        moc = 1'b0;
        mrd = $urandom;
    endtask

    // Full load request through to E or FAULT, checked against the model.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input int k1, input int k2,
                            input logic [31:0] w0, input logic [31:0] w1, input string tag);
        logic [31:0] wa;
        wa = a - (a % 4);
        checks++;
        if (busy !== 1'b0 || dq !== exp_dq || dq_hi !== exp_dq_hi || dsize !== exp_dsize) begin
            errors++;
            $display("FAIL %s hold: busy=%b dq=%h dq_hi=%h dsize=%b want busy=0 dq=%h dq_hi=%h dsize=%b",
                     tag, busy, dq, dq_hi, dsize, exp_dq, exp_dq_hi, exp_dsize);
        end
        start = 1'b1;
        addr  = a;
        size  = sz;
        step();
        start = 1'b0;
        addr  = $urandom;
        size  = 2'($urandom);
        if (!model_aligned(a, sz)) begin
            checks++;
            if (fault !== 1'b1 || fcode !== FC_MISALIGN || mov !== 1'b0 || e !== 1'b0) begin
                errors++;
                $display("FAIL %s misalign: fault=%b fcode=%b mov=%b e=%b want 1 0 0 0",
                         tag, fault, fcode, mov, e);
            end
            step();
            checks++;
            if (fault !== 1'b0 || busy !== 1'b0 || mov !== 1'b0 || e !== 1'b0 || dq !== exp_dq ||
                dq_hi !== exp_dq_hi || dsize !== exp_dsize) begin
                errors++;
                $display("FAIL %s after fault: fault=%b busy=%b mov=%b e=%b dq=%h want 0 0 0 0 dq=%h",
                         tag, fault, busy, mov, e, dq, exp_dq);
            end
            return;
        end
        access(wa, k1, w0, tag);
        if (sz == 2'b11) begin
            checks++;
            if (mov !== 1'b0 || e !== 1'b0 || busy !== 1'b1 || fault !== 1'b0) begin
                errors++;
                $display("FAIL %s gap: mov=%b e=%b busy=%b fault=%b want 0 0 1 0",
                         tag, mov, e, busy, fault);
            end
            moc = 1'b1;          // must be ignored while MOV is low
            mrd = $urandom;
            step();
            moc = 1'b0;
            access(wa + 32'd4, k2, w1, tag);
            exp_dq    = w0;
            exp_dq_hi = w1;
        end else begin
            exp_dq    = model_lane(w0, a, sz);
            exp_dq_hi = 32'h0;
        end
        exp_dsize = sz;
        checks++;
        if (e !== 1'b1 || mov !== 1'b0 || fault !== 1'b0 || dq !== exp_dq ||
            dq_hi !== exp_dq_hi || dsize !== exp_dsize) begin
            errors++;
            $display("FAIL %s done: e=%b mov=%b fault=%b dq=%h dq_hi=%h dsize=%b want e=1 mov=0 fault=0 dq=%h dq_hi=%h dsize=%b",
                     tag, e, mov, fault, dq, dq_hi, dsize, exp_dq, exp_dq_hi, exp_dsize);
        end
        step();
        checks++;
        if (e !== 1'b0 || busy !== 1'b0 || mov !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: e=%b busy=%b mov=%b want 0 0 0", tag, e, busy, mov);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clr   = 1'b1;
        start = 1'b1;
        moc   = 1'b1;
        addr  = $urandom;
        size  = 2'b11;
        mrd   = $urandom;
        repeat (3) step();
        checks++;
        if (mov !== 1'b0 || ma !== 32'h0 || dq !== 32'h0 || dq_hi !== 32'h0 || dsize !== 2'b00 ||
            e !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || fcode !== 1'b0) begin
            errors++;
            $display("FAIL reset: mov=%b ma=%h dq=%h dq_hi=%h dsize=%b e=%b busy=%b fault=%b fcode=%b want all 0",
                     mov, ma, dq, dq_hi, dsize, e, busy, fault, fcode);
        end
        clr   = 1'b0;
        start = 1'b0;
        moc   = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || mov !== 1'b0) begin
            errors++;
            $display("FAIL reset release: busy=%b mov=%b want 0 0", busy, mov);
        end
    endtask

    task automatic test_byte();
        run_load(32'h0000_0103, 2'b00, 2, 0, 32'hAABB_CCDD, 32'h0, "byte");
    endtask

    task automatic test_dword();
        run_load(32'h0000_0200, 2'b11, 1, 1, 32'h1111_1111, 32'h2222_2222, "dword");
    endtask

    task automatic test_misalign();
        run_load(32'h0000_0101, 2'b01, 0, 0, 32'h0, 32'h0, "misalign_half");
        run_load(32'h0000_0102, 2'b10, 0, 0, 32'h0, 32'h0, "misalign_word");
        run_load(32'h0000_0204, 2'b11, 0, 0, 32'h0, 32'h0, "misalign_dword");
    endtask

    // MOC never arrives; dword variant times out in the second access.
    task automatic test_timeout(input bit dword);
        string tag;
        tag   = dword ? "timeout_acc2" : "timeout_acc1";
        start = 1'b1;
        addr  = dword ? 32'h0000_0380 : 32'h0000_0340;
        size  = dword ? 2'b11 : 2'b10;
        step();
        start = 1'b0;
        if (dword) begin
            moc = 1'b1;
            mrd = $urandom;
            step();
            moc = 1'b0;
            checks++;
            if (mov !== 1'b0) begin
                errors++;
                $display("FAIL %s gap: mov=%b want 0", tag, mov);
            end
            step();
        end
        for (int i = 0; i < TIMEOUT; i++) begin
            checks++;
            if (mov !== 1'b1 || fault !== 1'b0) begin
                errors++;
                $display("FAIL %s wait cyc%0d: mov=%b fault=%b want 1 0", tag, i, mov, fault);
            end
            step();
        end
        checks++;
        if (fault !== 1'b1 || fcode !== FC_TIMEOUT || mov !== 1'b0 || e !== 1'b0 ||
            dq !== exp_dq || dq_hi !== exp_dq_hi || dsize !== exp_dsize) begin
            errors++;
            $display("FAIL %s fault: fault=%b fcode=%b mov=%b e=%b dq=%h dq_hi=%h want 1 1 0 0 dq=%h dq_hi=%h",
                     tag, fault, fcode, mov, e, dq, dq_hi, exp_dq, exp_dq_hi);
        end
        step();
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0 || mov !== 1'b0) begin
            errors++;
            $display("FAIL %s after: fault=%b busy=%b mov=%b want 0 0 0", tag, fault, busy, mov);
        end
    endtask

    // MOC on the last cycle before the limit still completes.
    task automatic test_timeout_boundary();
        run_load(32'h0000_0440, 2'b10, TIMEOUT - 1, 0, 32'hDEAD_BEEF, 32'h0, "late_moc_word");
        run_load(32'h0000_0448, 2'b11, TIMEOUT - 1, TIMEOUT - 1, 32'h0BAD_F00D, 32'h7654_3210,
                 "late_moc_dword");
    endtask

    task automatic test_clr_mid_op();
        start = 1'b1;
        addr  = 32'h0000_0408;
        size  = 2'b11;
        step();
        start = 1'b0;
        moc   = 1'b1;
        mrd   = 32'h5555_AAAA;
        step();
        moc   = 1'b0;
        step();
        checks++;
        if (mov !== 1'b1 || ma !== 32'h0000_040C) begin
            errors++;
            $display("FAIL clr acc2: mov=%b ma=%h want 1 0000040c", mov, ma);
        end
        step();
        moc = 1'b1;
        mrd = 32'h1234_5678;
        clr = 1'b1;
        step();
        moc = 1'b0;
        clr = 1'b0;
        checks++;
        if (mov !== 1'b0 || ma !== 32'h0 || dq !== 32'h0 || dq_hi !== 32'h0 || dsize !== 2'b00 ||
            e !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || fcode !== 1'b0) begin
            errors++;
            $display("FAIL clr: mov=%b ma=%h dq=%h dq_hi=%h dsize=%b e=%b busy=%b fault=%b fcode=%b want all 0",
                     mov, ma, dq, dq_hi, dsize, e, busy, fault, fcode);
        end
        exp_dq    = 32'h0;
        exp_dq_hi = 32'h0;
        exp_dsize = 2'b00;
        step();
        checks++;
        if (e !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL clr after: e=%b busy=%b fault=%b want 0 0 0", e, busy, fault);
        end
    endtask

    // START held high: ignored in ACC1/DONE, taken in the cycle after E.
    task automatic test_back_to_back();
        start = 1'b1;
        addr  = 32'h0000_0501;
        size  = 2'b00;
        step();
        addr  = 32'h0000_0600;
        size  = 2'b10;
        checks++;
        if (mov !== 1'b1 || ma !== 32'h0000_0500) begin
            errors++;
            $display("FAIL b2b acc1: mov=%b ma=%h want 1 00000500", mov, ma);
        end
        step();
        checks++;
        if (mov !== 1'b1 || ma !== 32'h0000_0500) begin
            errors++;
            $display("FAIL b2b start ignored: mov=%b ma=%h want 1 00000500", mov, ma);
        end
        moc = 1'b1;
        mrd = 32'h0102_0304;
        step();
        moc       = 1'b0;
        exp_dq    = model_lane(32'h0102_0304, 32'h0000_0501, 2'b00);
        exp_dq_hi = 32'h0;
        exp_dsize = 2'b00;
        checks++;
        if (e !== 1'b1 || dq !== exp_dq || dsize !== exp_dsize) begin
            errors++;
            $display("FAIL b2b first E: e=%b dq=%h dsize=%b want 1 %h %b", e, dq, dsize, exp_dq, exp_dsize);
        end
        step();
        checks++;
        if (e !== 1'b0 || busy !== 1'b0 || mov !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle: e=%b busy=%b mov=%b want 0 0 0", e, busy, mov);
        end
        step();
        start = 1'b0;
        checks++;
        if (mov !== 1'b1 || ma !== 32'h0000_0600 || dq !== exp_dq) begin
            errors++;
            $display("FAIL b2b second acc: mov=%b ma=%h dq=%h want 1 00000600 %h", mov, ma, dq, exp_dq);
        end
        moc = 1'b1;
        mrd = 32'hCAFE_F00D;
        step();
        moc       = 1'b0;
        exp_dq    = 32'hCAFE_F00D;
        exp_dsize = 2'b10;
        checks++;
        if (e !== 1'b1 || dq !== exp_dq || dq_hi !== 32'h0 || dsize !== exp_dsize) begin
            errors++;
            $display("FAIL b2b second E: e=%b dq=%h dq_hi=%h dsize=%b want 1 %h 0 %b",
                     e, dq, dq_hi, dsize, exp_dq, exp_dsize);
        end
        step();
        checks++;
        if (e !== 1'b0 || busy !== 1'b0 || mov !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: e=%b busy=%b mov=%b want 0 0 0", e, busy, mov);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            run_load(a, sz, $urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom, "random");
        end
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        moc   = 1'b0;
        addr  = 32'h0;
        size  = 2'b00;
        mrd   = 32'h0;
        test_reset();
        test_byte();
        test_dword();
        test_misalign();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_timeout_boundary();
        test_clr_mid_op();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
